// File: rtl/rv_pkg.sv
// Shared RV32IM encodings for the execute stage: opcodes, funct3/funct7 values
// and the iterative multiply/divide unit's state type.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;

   function automatic logic op_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with the sign fixed up combinationally in DONE.
module mdu_iterative
   import rv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MDU_ITERS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(MDU_ITERS);

   mdu_state_t         state, state_next;
   logic [CW-1:0]      count;
   logic [2*XLEN-1:0]  acc, acc_next, prod;
   logic [XLEN-1:0]    opb, a_save, quot, rem;
   logic [2:0]         op;
   logic               sa, sb, sa_q, sb_q, b_zero;
   logic [XLEN:0]      mul_sum, div_shift;
   logic [XLEN+1:0]    div_diff;

   assign sa = op_a_signed(funct3) & a[XLEN-1];
   assign sb = op_b_signed(funct3) & b[XLEN-1];

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (count == CW'(MDU_ITERS - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // acc holds {hi, lo}: product/multiplier for MUL*, remainder/quotient for DIV*/REM*
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opb};
      if (op[2]) begin
         if (!div_diff[XLEN+1]) acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else                   acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         opb    <= '0;
         a_save <= '0;
         op     <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (start) begin
               count  <= '0;
               op     <= funct3;
               a_save <= a;
               sa_q   <= sa;
               sb_q   <= sb;
               opb    <= sb ? -b : b;
               acc    <= {{XLEN{1'b0}}, (sa ? -a : a)};
            end
            RUN: begin
               count <= count + 1'b1;
               acc   <= acc_next;
            end
            default: count <= '0;
         endcase
      end
   end

   assign b_zero = (opb == '0);
   assign prod   = (sa_q ^ sb_q) ? -acc : acc;
   assign quot   = acc[XLEN-1:0];
   assign rem    = acc[2*XLEN-1:XLEN];

   always_comb begin
      result = '0;
      case (op)
         F3_MUL:                        result = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               result = b_zero ? '1 : ((sa_q ^ sb_q) ? -quot : quot);
         default:                       result = b_zero ? a_save : (sa_q ? -rem : rem);
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, address generation, branch resolution and iterative
// multiply/divide, feeding the internal EX/MEM register.
module ex_stage
   import rv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MDU_ITERS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] in_pc,
   input  logic [6:0]      in_alu_op,
   input  logic            in_alu_src,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic            in_mem_to_reg,
   input  logic            in_beq_control,
   input  logic            in_bneq_control,
   input  logic            in_blt_control,
   input  logic            in_bge_control,
   input  logic [XLEN-1:0] in_read_data_1,
   input  logic [XLEN-1:0] in_read_data_2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   input  logic [6:0]      in_funct7,
   input  logic [2:0]      in_funct3,
   output logic            stall,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            out_valid,
   output logic [XLEN-1:0] out_alu_result,
   output logic [XLEN-1:0] out_write_data,
   output logic [4:0]      out_rd,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_mem_to_reg
);

   logic [XLEN-1:0] op_a, op_b, alu_result, ex_result, mdu_result;
   logic [4:0]      shamt;
   logic            is_sub, is_mem, mdu_op, mdu_start, mdu_busy, mdu_done;
   logic            ex_valid, lt, br_cond;

   assign op_a   = in_read_data_1;
   assign op_b   = in_alu_src ? in_imm : in_read_data_2;
   assign shamt  = op_b[4:0];
   assign is_sub = (in_alu_op == OP_R) && in_funct7[5];
   assign is_mem = (in_alu_op == OP_LOAD) || (in_alu_op == OP_STORE);
   assign mdu_op = (in_alu_op == OP_R) && (in_funct7 == FUNCT7_MULDIV);

   always_comb begin
      alu_result = '0;
      case (in_funct3)
         F3_ADD:  alu_result = is_sub ? (op_a - op_b) : (op_a + op_b);
         F3_SLL:  alu_result = op_a << shamt;
         F3_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         F3_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
         F3_XOR:  alu_result = op_a ^ op_b;
         F3_SR:   alu_result = in_funct7[5] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
         F3_OR:   alu_result = op_a | op_b;
         default: alu_result = op_a & op_b;
      endcase
   end

   // The MDU holds the front end until its DONE cycle, where the result is captured
   assign mdu_start = mdu_op && !mdu_busy && !mdu_done;
   assign stall     = mdu_op && !mdu_done;

   mdu_iterative #(.XLEN(XLEN), .MDU_ITERS(MDU_ITERS)) u_mdu (
      .clk    (clk),
      .reset  (reset),
      .start  (mdu_start),
      .funct3 (in_funct3),
      .a      (in_read_data_1),
      .b      (in_read_data_2),
      .busy   (mdu_busy),
      .done   (mdu_done),
      .result (mdu_result)
   );

   assign lt      = $signed(in_read_data_1) < $signed(in_read_data_2);
   assign br_cond = (in_beq_control  && (in_read_data_1 == in_read_data_2)) ||
                    (in_bneq_control && (in_read_data_1 != in_read_data_2)) ||
                    (in_blt_control  && lt) ||
                    (in_bge_control  && !lt);
   assign branch_taken  = (in_alu_op == OP_BRANCH) && br_cond && !stall;
   assign branch_target = in_pc + in_imm;

   assign ex_valid  = ((in_alu_op == OP_R) || (in_alu_op == OP_I) || is_mem) && !stall;
   assign ex_result = mdu_op ? mdu_result : (is_mem ? (op_a + in_imm) : alu_result);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid      <= 1'b0;
         out_alu_result <= '0;
         out_write_data <= '0;
         out_rd         <= '0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
      end else begin
         out_valid      <= ex_valid;
         out_alu_result <= ex_result;
         out_write_data <= in_read_data_2;
         out_rd         <= in_rd;
         out_mem_read   <= in_mem_read   && ex_valid;
         out_mem_write  <= in_mem_write  && ex_valid;
         out_mem_to_reg <= in_mem_to_reg && ex_valid;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table for single-cycle ops and branches, MDU
// sequences with stall counting, and a reset-abort sequence.
module tb_ex_stage;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_pc, in_read_data_1, in_read_data_2, in_imm;
   logic [6:0]  in_alu_op, in_funct7;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic        in_alu_src, in_mem_read, in_mem_write, in_mem_to_reg;
   logic        in_beq_control, in_bneq_control, in_blt_control, in_bge_control;
   logic        stall, branch_taken, out_valid;
   logic [31:0] branch_target, out_alu_result, out_write_data;
   logic [4:0]  out_rd;
   logic        out_mem_read, out_mem_write, out_mem_to_reg;

   int checks   = 0;
   int failures = 0;

   // {check_result, valid, mem_read, mem_write, mem_to_reg, rd, result, write_data}
   logic [73:0] exp_q[$];

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        src;
      logic        mr, mw, m2r;
      logic [3:0]  br;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic        ev;
      logic        cr;
      logic [31:0] er;
      logic        et;
   } vec_t;

   vec_t vecs[$];

   ex_stage #(.XLEN(32), .MDU_ITERS(32)) dut (
      .clk(clk), .reset(reset), .in_pc(in_pc), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
      .in_beq_control(in_beq_control), .in_bneq_control(in_bneq_control),
      .in_blt_control(in_blt_control), .in_bge_control(in_bge_control),
      .in_read_data_1(in_read_data_1), .in_read_data_2(in_read_data_2), .in_imm(in_imm),
      .in_rd(in_rd), .in_funct7(in_funct7), .in_funct3(in_funct3),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .out_valid(out_valid), .out_alu_result(out_alu_result), .out_write_data(out_write_data),
      .out_rd(out_rd), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic src, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                               input logic [2:0] mem, input logic [3:0] br, input logic ev,
                               input logic cr, input logic [31:0] er, input logic et);
      vec_t v;
      v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.src = src;
      v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd; v.pc = 32'h40;
      {v.mr, v.mw, v.m2r} = mem; v.br = br;
      v.ev = ev; v.cr = cr; v.er = er; v.et = et;
      return v;
   endfunction

   task automatic set_in(input vec_t v);
      in_alu_op = v.op; in_funct3 = v.f3; in_funct7 = v.f7; in_alu_src = v.src;
      in_read_data_1 = v.rs1; in_read_data_2 = v.rs2; in_imm = v.imm; in_rd = v.rd; in_pc = v.pc;
      in_mem_read = v.mr; in_mem_write = v.mw; in_mem_to_reg = v.m2r;
      {in_beq_control, in_bneq_control, in_blt_control, in_bge_control} = v.br;
   endtask

   function automatic logic [73:0] pack_exp(input vec_t v);
      return {v.cr, v.ev, v.mr & v.ev, v.mw & v.ev, v.m2r & v.ev, v.rd, v.er, v.rs2};
   endfunction

   task automatic compare_out(input string n);
      logic [73:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard_empty actual=0 required=1", n);
         return;
      end
      e = exp_q.pop_front();
      check32({n, " valid"}, {31'd0, out_valid}, {31'd0, e[72]});
      if (e[72]) begin
         check32({n, " mem_ctl"}, {29'd0, out_mem_read, out_mem_write, out_mem_to_reg}, {29'd0, e[71:69]});
         check32({n, " rd"}, {27'd0, out_rd}, {27'd0, e[68:64]});
         check32({n, " write_data"}, out_write_data, e[31:0]);
      end else begin
         check32({n, " mem_ctl_zero"}, {29'd0, out_mem_read, out_mem_write, out_mem_to_reg}, 32'd0);
      end
      if (e[73]) check32({n, " result"}, out_alu_result, e[63:32]);
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      set_in(v);
      #1;
      check32({v.name, " taken"}, {31'd0, branch_taken}, {31'd0, v.et});
      check32({v.name, " stall"}, {31'd0, stall}, 32'd0);
      if (v.op == OP_BRANCH) check32({v.name, " target"}, branch_target, v.pc + v.imm);
      exp_q.push_back(pack_exp(v));
      @(posedge clk);
      #1;
      compare_out(v.name);
   endtask

   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0] up;
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         F3_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         F3_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
         F3_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
         F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
         F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic run_mdu(input string n, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er);
      vec_t v;
      int cnt;
      int vseen;
      v = mk(n, OP_R, f3, FUNCT7_MULDIV, 1'b0, a, b, 32'd0, 5'd9, 3'b000, 4'b0000, 1'b1, 1'b1, er, 1'b0);
      @(negedge clk);
      set_in(v);
      #1;
      exp_q.push_back(pack_exp(v));
      cnt = 0;
      vseen = 0;
      while (stall && cnt < 40) begin
         cnt++;
         @(negedge clk);
         #1;
         if (out_valid) vseen++;
      end
      check32({n, " stall_cycles"}, cnt, 33);
      check32({n, " valid_during_stall"}, vseen, 0);
      @(posedge clk);
      #1;
      compare_out(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic [31:0] a, b;
      logic [2:0]  f3;

      // Reset while a live ADD is presented: EX/MEM must stay cleared
      reset = 1'b1;
      set_in(mk("rst", OP_R, F3_ADD, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 3'b111, 4'b0000, 1'b0, 1'b0, 32'd0, 1'b0));
      repeat (2) @(posedge clk);
      #1;
      check32("reset valid", {31'd0, out_valid}, 32'd0);
      check32("reset result", out_alu_result, 32'd0);
      check32("reset rd", {27'd0, out_rd}, 32'd0);
      check32("reset mem_ctl", {29'd0, out_mem_read, out_mem_write, out_mem_to_reg}, 32'd0);
      check32("reset stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      vecs.push_back(mk("add",   OP_R, F3_ADD,  7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 3'b000, 4'b0000, 1'b1, 1'b1, 32'd12, 1'b0));
      vecs.push_back(mk("sub",   OP_R, F3_ADD,  7'h20, 1'b0, 32'd5, 32'd7, 32'd0, 5'd4, 3'b000, 4'b0000, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0));
      vecs.push_back(mk("addi_nosub", OP_I, F3_ADD, 7'h20, 1'b1, 32'd5, 32'd0, 32'h400, 5'd5, 3'b000, 4'b0000, 1'b1, 1'b1, 32'h405, 1'b0));
      vecs.push_back(mk("sll",   OP_R, F3_SLL,  7'h00, 1'b0, 32'd1, 32'h24, 32'd0, 5'd6, 3'b000, 4'b0000, 1'b1, 1'b1, 32'h10, 1'b0));
      vecs.push_back(mk("slt",   OP_R, F3_SLT,  7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd7, 3'b000, 4'b0000, 1'b1, 1'b1, 32'd1, 1'b0));
      vecs.push_back(mk("sltu",  OP_R, F3_SLTU, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd8, 3'b000, 4'b0000, 1'b1, 1'b1, 32'd0, 1'b0));
      vecs.push_back(mk("xor",   OP_R, F3_XOR,  7'h00, 1'b0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'd0, 5'd9, 3'b000, 4'b0000, 1'b1, 1'b1, 32'hAAAA_AAAA, 1'b0));
      vecs.push_back(mk("srl",   OP_R, F3_SR,   7'h00, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd10, 3'b000, 4'b0000, 1'b1, 1'b1, 32'h0800_0000, 1'b0));
      vecs.push_back(mk("sra",   OP_R, F3_SR,   7'h20, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd11, 3'b000, 4'b0000, 1'b1, 1'b1, 32'hF800_0000, 1'b0));
      vecs.push_back(mk("srai",  OP_I, F3_SR,   7'h20, 1'b1, 32'hF000_0000, 32'd0, 32'h404, 5'd12, 3'b000, 4'b0000, 1'b1, 1'b1, 32'hFF00_0000, 1'b0));
      vecs.push_back(mk("or",    OP_R, F3_OR,   7'h00, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 32'd0, 5'd13, 3'b000, 4'b0000, 1'b1, 1'b1, 32'h0000_0FF0, 1'b0));
      vecs.push_back(mk("and",   OP_R, F3_AND,  7'h00, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 5'd14, 3'b000, 4'b0000, 1'b1, 1'b1, 32'h0F00_0F00, 1'b0));
      vecs.push_back(mk("load",  OP_LOAD, 3'b010, 7'h00, 1'b1, 32'h1000, 32'd0, 32'hFFFF_FFFC, 5'd15, 3'b101, 4'b0000, 1'b1, 1'b1, 32'h0000_0FFC, 1'b0));
      vecs.push_back(mk("store", OP_STORE, 3'b010, 7'h00, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'd8, 5'd0, 3'b010, 4'b0000, 1'b1, 1'b1, 32'h2008, 1'b0));
      vecs.push_back(mk("blt",   OP_BRANCH, 3'b100, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 3'b000, 4'b0010, 1'b0, 1'b0, 32'd0, 1'b1));
      vecs.push_back(mk("bge",   OP_BRANCH, 3'b101, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 3'b000, 4'b0001, 1'b0, 1'b0, 32'd0, 1'b0));
      vecs.push_back(mk("beq",   OP_BRANCH, 3'b000, 7'h00, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFF0, 5'd0, 3'b000, 4'b1000, 1'b0, 1'b0, 32'd0, 1'b1));
      vecs.push_back(mk("bneq",  OP_BRANCH, 3'b001, 7'h00, 1'b0, 32'd9, 32'd9, 32'h20, 5'd0, 3'b000, 4'b0100, 1'b0, 1'b0, 32'd0, 1'b0));
      vecs.push_back(mk("bubble", 7'h00, 3'b000, 7'h00, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 3'b111, 4'b0000, 1'b0, 1'b0, 32'd0, 1'b0));
      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

      // Random ADD/SUB/XOR against a plain operator model
      for (int i = 0; i < 8; i++) begin
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 2))
            0:       v = mk("rnd_add", OP_R, F3_ADD, 7'h00, 1'b0, a, b, 32'd0, 5'($urandom_range(1, 31)), 3'b000, 4'b0000, 1'b1, 1'b1, a + b, 1'b0);
            1:       v = mk("rnd_sub", OP_R, F3_ADD, 7'h20, 1'b0, a, b, 32'd0, 5'($urandom_range(1, 31)), 3'b000, 4'b0000, 1'b1, 1'b1, a - b, 1'b0);
            default: v = mk("rnd_xor", OP_R, F3_XOR, 7'h00, 1'b0, a, b, 32'd0, 5'($urandom_range(1, 31)), 3'b000, 4'b0000, 1'b1, 1'b1, a ^ b, 1'b0);
         endcase
         apply_vec(v);
      end

      // Directed MDU corners, issued back to back
      run_mdu("mul",     F3_MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      run_mdu("mulhu",   F3_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
      run_mdu("mulh",    F3_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      run_mdu("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      run_mdu("div_by0", F3_DIV,    32'd7, 32'd0, 32'hFFFF_FFFF);
      run_mdu("rem_by0", F3_REM,    32'd7, 32'd0, 32'd7);
      run_mdu("div_ovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_mdu("rem_ovf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_mdu("divu",    F3_DIVU,   32'd100, 32'd7, 32'd14);
      run_mdu("remu",    F3_REMU,   32'd100, 32'd7, 32'd2);
      run_mdu("div_neg", F3_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_mdu("rem_neg", F3_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

      for (int i = 0; i < 6; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i == 5) ? 32'd0 : $urandom;
         run_mdu("rnd_mdu", f3, a, b, ref_mdu(f3, a, b));
      end

      // Reset at iteration 10 of a DIV aborts it; the pipeline must recover cleanly
      @(negedge clk);
      set_in(mk("div_abort", OP_R, F3_DIV, FUNCT7_MULDIV, 1'b0, 32'd100, 32'd7, 32'd0, 5'd2, 3'b000, 4'b0000, 1'b0, 1'b0, 32'd0, 1'b0));
      repeat (11) @(negedge clk);
      #1;
      check32("abort stall_before_reset", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      set_in(mk("bub", 7'h00, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 4'b0000, 1'b0, 1'b0, 32'd0, 1'b0));
      @(posedge clk);
      #1;
      check32("abort stall", {31'd0, stall}, 32'd0);
      check32("abort valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      apply_vec(mk("add_after_abort", OP_R, F3_ADD, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 3'b000, 4'b0000, 1'b1, 1'b1, 32'd12, 1'b0));
      run_mdu("divu_after_abort", F3_DIVU, 32'd100, 32'd7, 32'd14);

      check32("scoreboard drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
